// File: rtl/c1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : c1_bus_arbiter
// Two-client round-robin master for the C1 cache bus (address/data beats,
// response wait, read return). Optional macro: C1_TIMEOUT_EN (WAIT watchdog).
// Rev    : 1.0
// ============================================================================
module c1_bus_arbiter #(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [1:0]                            req,
  input  logic [5:0]                            req_cmd,
  input  logic [2*MEM_ADDR_SIZE-1:0]            req_addr,
  input  logic [4*BUS_SIZE-1:0]                 req_wdata,
  output logic [1:0]                            grant,
  output logic [1:0]                            done,
  output logic [2*BUS_SIZE-1:0]                 rdata,
  output logic                                  err,
  output logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address,
  inout  wire  [BUS_SIZE-1:0]                   data,
  inout  wire  [2:0]                            command
);

  localparam int AW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;

  localparam logic [2:0] C_NOP     = 3'd0;
  localparam logic [2:0] C_READ8   = 3'd1;
  localparam logic [2:0] C_READ16  = 3'd2;
  localparam logic [2:0] C_READ32  = 3'd3;
  localparam logic [2:0] C_WRITE8  = 3'd5;
  localparam logic [2:0] C_WRITE16 = 3'd6;
  localparam logic [2:0] C_WR32    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEND1 = 3'd1,
    S_SEND2 = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP2 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  if (CACHE_OFFSET_SIZE >= AW || BUS_SIZE < 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("c1_bus_arbiter: unsupported parameter set");
  end

  state_t                   r_state;
  logic                     r_ptr;
  logic                     r_sel;
  logic [2:0]               r_cmd;
  logic [MEM_ADDR_SIZE-1:0] r_addr;
  logic [2*BUS_SIZE-1:0]    r_wdata;

  logic                     w_pick;
  logic [2:0]               w_pick_cmd;
  logic                     w_resp;
  logic                     w_is_write;
  logic                     w_addr_en;
  logic                     w_data_en;
  logic                     w_cmd_en;
  logic [AW-1:0]            w_addr_drv;
  logic [BUS_SIZE-1:0]      w_data_drv;

  // Pointer only matters on a tie; a lone requester always wins.
  assign w_pick     = (req == 2'b11) ? r_ptr : req[1];
  assign w_pick_cmd = w_pick ? req_cmd[5:3] : req_cmd[2:0];
  assign w_resp     = (command == C_WR32);
  assign w_is_write = (r_cmd == C_WRITE8) || (r_cmd == C_WRITE16) || (r_cmd == C_WR32);

  always_comb begin
    w_addr_en  = 1'b0;
    w_data_en  = 1'b0;
    w_cmd_en   = 1'b0;
    w_addr_drv = '0;
    w_data_drv = r_wdata[BUS_SIZE-1:0];
    case (r_state)
      S_SEND1: begin
        w_addr_en  = 1'b1;
        w_cmd_en   = 1'b1;
        w_data_en  = w_is_write;
        w_addr_drv = r_addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE];
      end
      S_SEND2: begin
        w_addr_en  = 1'b1;
        w_cmd_en   = 1'b1;
        w_data_en  = w_is_write;
        w_addr_drv = {{(AW-CACHE_OFFSET_SIZE){1'b0}}, r_addr[CACHE_OFFSET_SIZE-1:0]};
        if (r_cmd == C_WR32) begin
          w_data_drv = r_wdata[2*BUS_SIZE-1:BUS_SIZE];
        end
      end
      default: ;
    endcase
  end

  assign address = w_addr_en ? w_addr_drv : 'z;
  assign data    = w_data_en ? w_data_drv : 'z;
  assign command = w_cmd_en  ? r_cmd      : 'z;

`ifdef C1_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;
  logic             r_abort;
  logic             r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_sel   <= 1'b0;
      r_cmd   <= C_NOP;
      r_addr  <= '0;
      r_wdata <= '0;
      grant   <= 2'b00;
      done    <= 2'b00;
      rdata   <= '0;
`ifdef C1_TIMEOUT_EN
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else begin
      done <= 2'b00;
`ifdef C1_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_sel   <= w_pick;
            r_ptr   <= ~w_pick;
            r_cmd   <= w_pick_cmd;
            r_addr  <= w_pick ? req_addr[2*MEM_ADDR_SIZE-1:MEM_ADDR_SIZE]
                              : req_addr[MEM_ADDR_SIZE-1:0];
            r_wdata <= w_pick ? req_wdata[4*BUS_SIZE-1:2*BUS_SIZE]
                              : req_wdata[2*BUS_SIZE-1:0];
            grant   <= w_pick ? 2'b10 : 2'b01;
            r_state <= (w_pick_cmd == C_NOP) ? S_DONE : S_SEND1;
          end
        end
        S_SEND1: r_state <= S_SEND2;
        S_SEND2: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_resp) begin
            case (r_cmd)
              C_READ8:  rdata <= {{(2*BUS_SIZE-8){1'b0}}, data[7:0]};
              C_READ16: rdata <= {{BUS_SIZE{1'b0}}, data};
              C_READ32: rdata[BUS_SIZE-1:0] <= data;
              default:  ;
            endcase
            r_state <= (r_cmd == C_READ32) ? S_RESP2 : S_DONE;
`ifdef C1_TIMEOUT_EN
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_abort <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
`endif
          end
        end
        S_RESP2: begin
          rdata[2*BUS_SIZE-1:BUS_SIZE] <= data;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= r_sel ? 2'b10 : 2'b01;
          grant   <= 2'b00;
          r_state <= S_IDLE;
`ifdef C1_TIMEOUT_EN
          r_err   <= r_abort;
          r_abort <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c1_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_c1_bus_arbiter
// Randomized self-checking bench for c1_bus_arbiter with a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_c1_bus_arbiter;

  localparam int MAW = 19;
  localparam int BW  = 16;
  localparam int OFS = 4;
  localparam int TO  = 16;
  localparam int AW  = MAW - OFS;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [5:0]       req_cmd;
  logic [2*MAW-1:0] req_addr;
  logic [4*BW-1:0]  req_wdata;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic [2*BW-1:0]  rdata;
  logic             err;
  logic [AW-1:0]    address;
  tri   [BW-1:0]    data;
  tri   [2:0]       command;

  logic             cache_en;
  logic [BW-1:0]    cache_data;

  assign data    = cache_en ? cache_data : 'z;
  assign command = cache_en ? 3'd7 : 'z;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]    exp_rdata;
  int             exp_ptr;
  logic [2:0]     t_cmd  [2];
  logic [MAW-1:0] t_addr [2];
  logic [31:0]    t_wd   [2];

  always #5 clk = ~clk;

  c1_bus_arbiter #(
    .MEM_ADDR_SIZE(MAW), .BUS_SIZE(BW), .CACHE_OFFSET_SIZE(OFS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wdata(req_wdata), .grant(grant), .done(done), .rdata(rdata), .err(err),
    .address(address), .data(data), .command(command)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // A released bus reads as Z in a 4-state simulator and as 0 in a 2-state one.
  function automatic logic addr_idle();
    return $isunknown(address) || (address == '0);
  endfunction
  function automatic logic cmd_idle();
    return $isunknown(command) || (command == '0);
  endfunction
  function automatic logic data_idle();
    return $isunknown(data) || (data == '0);
  endfunction

  task automatic post(input int c, input logic [2:0] cmd, input logic [MAW-1:0] a,
                      input logic [31:0] wd);
    t_cmd[c]  = cmd;
    t_addr[c] = a;
    t_wd[c]   = wd;
    req[c]    = 1'b1;
    req_cmd[3*c +: 3]       = cmd;
    req_addr[MAW*c +: MAW]  = a;
    req_wdata[32*c +: 32]   = wd;
  endtask

  // Called at the negedge before the posedge where client c is expected to win.
  task automatic serve(input int c, input int d, input logic [15:0] lo,
                       input logic [15:0] hi, input bit abort_wait);
    logic [2:0]     cmd;
    logic [MAW-1:0] a;
    logic [31:0]    wd;
    bit             wr;
    logic [1:0]     g;
    cmd = t_cmd[c];
    a   = t_addr[c];
    wd  = t_wd[c];
    wr  = (cmd >= 3'd5);
    g   = (c == 1) ? 2'b10 : 2'b01;
    exp_ptr = 1 - c;

    @(negedge clk);
    check_val("grant", grant, g);
    check_val("done_single_cycle", done, 2'b00);
    if (cmd == 3'd0) begin
      check_val("nop_addr_idle", addr_idle(), 1'b1);
      check_val("nop_cmd_idle", cmd_idle(), 1'b1);
      @(negedge clk);
    end else begin
      check_val("send1_cmd", command, cmd);
      check_val("send1_addr", address, a[MAW-1:OFS]);
      if (wr) check_val("send1_data", data, wd[15:0]);
      else    check_val("send1_data_idle", data_idle(), 1'b1);
      if ($urandom_range(1, 0) == 1) req[c] = 1'b0;
      req_cmd[3*c +: 3]     = 3'($urandom);
      req_addr[MAW*c +: MAW] = MAW'($urandom);
      req_wdata[32*c +: 32] = $urandom;

      @(negedge clk);
      check_val("send2_cmd", command, cmd);
      check_val("send2_addr", address, AW'(a[OFS-1:0]));
      if (cmd == 3'd7)  check_val("send2_data", data, wd[31:16]);
      else if (wr)      check_val("send2_data", data, wd[15:0]);
      else              check_val("send2_data_idle", data_idle(), 1'b1);

      @(negedge clk);
      check_val("wait_cmd_idle", cmd_idle(), 1'b1);
      check_val("wait_addr_idle", addr_idle(), 1'b1);
      check_val("wait_grant", grant, g);
      if (abort_wait) begin
        reset  = 1'b1;
        req[c] = 1'b0;
        #1;
        check_val("rst_grant", grant, 2'b00);
        check_val("rst_addr_idle", addr_idle(), 1'b1);
        check_val("rst_cmd_idle", cmd_idle(), 1'b1);
        check_val("rst_data_idle", data_idle(), 1'b1);
        @(negedge clk);
        check_val("rst_no_done", done, 2'b00);
        reset     = 1'b0;
        exp_rdata = '0;
        exp_ptr   = 0;
        return;
      end
      repeat (d) @(negedge clk);
      cache_data = lo;
      cache_en   = 1'b1;
      @(negedge clk);
      if (cmd == 3'd3) begin
        cache_data = hi;
        @(negedge clk);
      end
      cache_en = 1'b0;
      check_val("done_early", done, 2'b00);
      @(negedge clk);
    end

    case (cmd)
      3'd1:    exp_rdata = {24'h0, lo[7:0]};
      3'd2:    exp_rdata = {16'h0, lo};
      3'd3:    exp_rdata = {hi, lo};
      default: ;
    endcase
    check_val("done", done, g);
    check_val("err", err, 1'b0);
    check_val("grant_drop", grant, 2'b00);
    check_val("rdata", rdata, exp_rdata);
    req[c] = 1'b0;
  endtask

  task automatic serve_rand(input int c);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'($urandom);
    hi = 16'($urandom);
    if (t_cmd[c] == 3'd1) lo[15:8] = 8'h00;
    serve(c, $urandom_range(6, 0), lo, hi, 1'b0);
  endtask

  // Cache never answers a WRITE16 from client 0.
  task automatic silent_txn();
    int n;
    bit bad;
    n   = 0;
    bad = 1'b0;
    post(0, 3'd6, 19'h12345, 32'hCAFE_0001);
    exp_ptr = 1;
    repeat (3) @(negedge clk);
`ifdef C1_TIMEOUT_EN
    while (!bad && n < 40) begin
      @(negedge clk);
      n++;
      if (done != 2'b00) bad = 1'b1;
    end
    // DONE is entered after the 16th empty WAIT sample; the pulse follows one cycle later.
    check_val("timeout_cycles", n, 17);
    check_val("timeout_done", done, 2'b01);
    check_val("timeout_err", err, 1'b1);
    check_val("timeout_rdata", rdata, exp_rdata);
    req[0] = 1'b0;
    @(negedge clk);
    check_val("timeout_err_pulse", err, 1'b0);
`else
    repeat (1000) begin
      @(negedge clk);
      if (done != 2'b00 || grant != 2'b01) bad = 1'b1;
    end
    check_val("wait_forever", bad, 1'b0);
    reset  = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    exp_rdata = '0;
    exp_ptr   = 0;
`endif
  endtask

  initial begin
    int first;
    int mask;
    reset      = 1'b1;
    req        = 2'b00;
    req_cmd    = '0;
    req_addr   = '0;
    req_wdata  = '0;
    cache_en   = 1'b0;
    cache_data = '0;
    exp_rdata  = '0;
    exp_ptr    = 0;
    repeat (3) @(negedge clk);
    check_val("reset_grant", grant, 2'b00);
    check_val("reset_done", done, 2'b00);
    check_val("reset_err", err, 1'b0);
    check_val("reset_rdata", rdata, 32'h0);
    check_val("reset_addr_idle", addr_idle(), 1'b1);
    check_val("reset_cmd_idle", cmd_idle(), 1'b1);
    reset = 1'b0;
    @(negedge clk);

    post(0, 3'd7, 19'h000E0, 32'hF0F0_0F0F);
    serve(0, 5, 16'h0000, 16'h0000, 1'b0);
    post(1, 3'd3, 19'h000A0, 32'h0);
    serve(1, 2, 16'h5555, 16'hFFFF, 1'b0);

    for (int r = 0; r < 2; r++) begin
      post(0, 3'd1, 19'h00100, 32'h0);
      post(1, 3'd1, 19'h00200, 32'h0);
      first = exp_ptr;
      serve(first, 1, 16'h00AB, 16'h0, 1'b0);
      serve(1 - first, 3, 16'h00AB, 16'h0, 1'b0);
    end

    post(0, 3'd0, 19'h7FFFF, 32'h0);
    serve(0, 0, 16'h0, 16'h0, 1'b0);

    post(0, 3'd6, 19'h0ABCD, 32'h1234_5678);
    serve(0, 0, 16'h0, 16'h0, 1'b1);
    post(1, 3'd2, 19'h01234, 32'h0);
    serve(1, 1, 16'hBEEF, 16'h0, 1'b0);

    silent_txn();
    @(negedge clk);

    for (int it = 0; it < 60; it++) begin
      mask = $urandom_range(3, 1);
      for (int c = 0; c < 2; c++) begin
        if (mask[c]) post(c, 3'($urandom), MAW'($urandom), $urandom);
      end
      first = (mask == 3) ? exp_ptr : ((mask == 2) ? 1 : 0);
      serve_rand(first);
      if (mask == 3) serve_rand(1 - first);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/c1_bus_arbiter.md
Name: c1_bus_arbiter

Overview:
- Synthesizable two-requester master for the C1 cache bus (3-bit command, 16-bit data, split address).
- Accepts whole-word transactions from two clients and arbitrates round-robin between them.
- Sequences the two-beat address/data C1 protocol, waits for the cache response, returns read data and a done pulse.
- Sits between the CPU-side clients and the cache's C1 port.

Parameters:
MEM_ADDR_SIZE, 19, full byte address width (tag+set+offset)
BUS_SIZE, 16, C1 data bus width
CACHE_OFFSET_SIZE, 4, offset bits sent on the second address beat
TIMEOUT_CYCLES, 255, response watchdog limit (used only with C1_TIMEOUT_EN)

Ports:
clk  input  1  clock; all state on posedge
reset  input  1  asynchronous, active-high
req  input  2  req[i] high = client i has a pending transaction; held until done[i]
req_cmd  input  2*3  client i command in bits [3i+2:3i]; C1 encodings 0..7
req_addr  input  2*MEM_ADDR_SIZE  client i byte address
req_wdata  input  2*2*BUS_SIZE  client i write data (32 bits each)
grant  output  2  one-hot; client being served, held from SEND1 through DONE
done  output  2  one-cycle pulse on completion for client i
rdata  output  2*BUS_SIZE  read result; valid in the done cycle, held until next done
err  output  1  high with done when transaction aborted; constant 0 without macro
address  output  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  C1 address bus; Z when not driving
data  inout  BUS_SIZE  C1 data bus
command  inout  3  C1 command bus

Behaviour:
- Reset (async, immediate): state IDLE; address/data/command = Z; grant=0, done=0, err=0, rdata=0; RR pointer = client 0 preferred.
- Commands: NOP=0, READ8=1, READ16=2, READ32=3, INV_LINE=4, WRITE8=5, WRITE16=6, WRITE32_RESP=7. The cache signals a response by driving 7 on command.
- IDLE: if any req is set, pick a client. With one requester, that requester wins. With both, the pointer client wins, then the pointer moves to the other client. Latch cmd/addr/wdata; assert grant; go to SEND1.
  - A latched NOP skips bus activity: go straight to DONE (done next cycle).
- SEND1 (1 cycle):
  - command = latched cmd.
  - address = addr[MEM_ADDR_SIZE-1:CACHE_OFFSET_SIZE].
  - data = wdata[15:0] for 5/6/7, else Z.
- SEND2 (1 cycle):
  - command = latched cmd.
  - address = zero-extended addr[CACHE_OFFSET_SIZE-1:0].
  - data = wdata[31:16] for 7, wdata[15:0] for 5/6, else Z.
- WAIT: command, address and data = Z. Sample command each posedge.
  - On command==7: capture data into rdata[15:0]; for READ32 go to RESP2, else go to DONE.
  - While the response is absent, stay in WAIT indefinitely (no macro).
- RESP2: capture data into rdata[31:16]; go to DONE.
- rdata zero-fills unused high bits for READ8/READ16; writes and INV_LINE leave rdata unchanged.
- DONE: done[granted]=1 for exactly one cycle; grant drops; return to IDLE. A new grant is possible on the next cycle.
- Latency (request seen at posedge 0, response first sampled at posedge k≥3):
  - Non-READ32: done asserted after posedge k+1.
  - READ32: done asserted after posedge k+2.
- Req deassertion mid-transaction is ignored; the transaction completes.
- Changes to req_* after grant are ignored.
- Response seen during SEND1/SEND2 is ignored (the master owns the bus then).
- Reset mid-transaction: bus released in the same cycle; no done pulse.

Optional Feature:
- C1_TIMEOUT_EN defined:
  - An 8+ bit counter runs in WAIT.
  - If no response arrives within TIMEOUT_CYCLES cycles of entering WAIT: go to DONE with err=1; rdata unchanged.
  - The counter clears on leaving WAIT.
- Undefined: no counter; WAIT waits forever; err tied 0.

Test Plan:
- Client0 WRITE32, addr 0x000E0, wdata 0xF0F00F0F; cache responds 5 cycles after SEND2 -> bus shows cmd 7/addr 0x0000E/data 0x0F0F, then cmd 7/addr 0x0/data 0xF0F0; done[0] pulses once; err=0.
- Client1 READ32 addr 0x000A0; cache responds with 0x5555 then 0xFFFF -> rdata=0xFFFF5555 with done[1]; command Z during WAIT.
- Both req set from reset, both READ8 -> client0 granted first, client1 second; repeat both -> client0 then client1 again (pointer alternates); rdata for READ8 response 0x00AB = 0x000000AB.
- Client0 NOP -> done[0] two cycles after req, no bus activity (address/command stay Z).
- Assert reset during WAIT of a WRITE16 -> all buses Z and grant=0 immediately; no done; next request starts cleanly at SEND1.
- With C1_TIMEOUT_EN and TIMEOUT_CYCLES=16, cache silent -> done with err=1 exactly 16 cycles after WAIT entry; without macro, still in WAIT after 1000 cycles.
